// File: rtl/wb_dma_arbiter_pkg.sv
// Shared types and constants for the Wishbone DMA bus-ownership arbiter.
package wb_dma_arbiter_pkg;

    localparam int MAX_NDMA   = 4;
    localparam int PTR_W      = 2;
    localparam int CPU_CNT_W  = 8;
    localparam int HOLD_CNT_W = 16;

    typedef enum logic [1:0] {
        ARB_CPU  = 2'd0,
        ARB_DROP = 2'd1,
        ARB_DMA  = 2'd2,
        ARB_REL  = 2'd3
    } arb_state_e;

    // Index of the set bit of a one-hot requester vector.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_NDMA-1:0] oh);
        return {oh[2] | oh[3], oh[1] | oh[3]};
    endfunction

endpackage

// File: rtl/wb_dma_arbiter_pick.sv
// Combinational winner select: first asserted request at or after ptr_i, wrapping.
module wb_dma_arbiter_pick
    import wb_dma_arbiter_pkg::*;
#(
    parameter int NDMA = 2
) (
    input  logic [NDMA-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NDMA-1:0]  win_o,
    output logic             valid_o
);

    logic [NDMA-1:0] rot;
    logic [NDMA-1:0] rot_win;

    // Rotate so the search start sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot     = NDMA'({req_i, req_i} >> ptr_i);
    assign rot_win = rot & (~rot + NDMA'(1));
    assign win_o   = NDMA'(({rot_win, rot_win} << ptr_i) >> NDMA);
    assign valid_o = |req_i;

endmodule

// File: rtl/wb_dma_arbiter.sv
// Wishbone bus-ownership arbiter: CPU is default owner, DMA masters take over at cycle boundaries.
// Define WB_ARB_RR_EN for round-robin among DMA masters; otherwise lowest index wins.
module wb_dma_arbiter
    import wb_dma_arbiter_pkg::*;
#(
    parameter int NDMA     = 2,
    parameter int MAX_HOLD = 0,
    parameter int CPU_MIN  = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cpu_cyc_i,
    output logic            cpu_gnt_o,
    input  logic [NDMA-1:0] dma_req_i,
    input  logic [NDMA-1:0] dma_cyc_i,
    output logic [NDMA-1:0] dma_gnt_o,
    output logic            preempt_o
);

    arb_state_e             state_q, state_d;
    logic                   cpu_gnt_q, cpu_gnt_d;
    logic [NDMA-1:0]        dma_gnt_q, dma_gnt_d;
    logic                   preempt_q, preempt_d;
    logic [NDMA-1:0]        win_q, win_d;
    logic [CPU_CNT_W-1:0]   cpu_cnt_q, cpu_cnt_d;
    logic [HOLD_CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PTR_W-1:0]       ptr;
    logic [NDMA-1:0]        pick_win;
    logic                   pick_valid;
    logic                   win_req;
    logic                   win_cyc;
    logic                   cpu_min_ok;
    logic                   hold_hit;

    wb_dma_arbiter_pick #(.NDMA(NDMA)) u_pick (
        .req_i   (dma_req_i),
        .ptr_i   (ptr),
        .win_o   (pick_win),
        .valid_o (pick_valid)
    );

    assign win_req    = |(dma_req_i & win_q);
    assign win_cyc    = |(dma_cyc_i & win_q);
    assign cpu_min_ok = ({1'b0, cpu_cnt_q} + 9'd1) >= 9'(CPU_MIN);

    generate
        if (MAX_HOLD == 0) begin : g_no_hold
            assign hold_hit = 1'b0;
        end else begin : g_hold
            assign hold_hit = ({1'b0, hold_cnt_q} + 17'd1) >= 17'(MAX_HOLD);
        end
    endgenerate

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_idx;

    assign win_idx = onehot_to_idx(MAX_NDMA'(win_q));

    // Next search starts one past the master that just took the bus.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_DROP && state_d == ARB_DMA) begin
            ptr_d = (win_idx == PTR_W'(NDMA - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ARB_CPU;
            cpu_gnt_q  <= 1'b1;
            dma_gnt_q  <= '0;
            preempt_q  <= 1'b0;
            win_q      <= '0;
            cpu_cnt_q  <= '1;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cpu_gnt_q  <= cpu_gnt_d;
            dma_gnt_q  <= dma_gnt_d;
            preempt_q  <= preempt_d;
            win_q      <= win_d;
            cpu_cnt_q  <= cpu_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_CPU:  if (pick_valid && !cpu_cyc_i && cpu_min_ok) state_d = ARB_DROP;
            ARB_DROP: state_d = win_req ? ARB_DMA : ARB_CPU;
            ARB_DMA:  if (!win_req || hold_hit) state_d = ARB_REL;
            ARB_REL:  if (!win_cyc) state_d = ARB_CPU;
            default:  state_d = ARB_CPU;
        endcase
    end

    // Outputs are registered from the next state so grants change exactly on the transition edge.
    always_comb begin
        cpu_gnt_d  = (state_d == ARB_CPU);
        dma_gnt_d  = (state_d == ARB_DMA) ? win_q : '0;
        preempt_d  = (state_q == ARB_DMA) && win_req && hold_hit;
        win_d      = (state_q == ARB_CPU && state_d == ARB_DROP) ? pick_win : win_q;
        cpu_cnt_d  = '0;
        hold_cnt_d = '0;
        if (state_q == ARB_CPU) begin
            cpu_cnt_d = (cpu_cnt_q == '1) ? cpu_cnt_q : cpu_cnt_q + CPU_CNT_W'(1);
        end
        if (state_q == ARB_DMA) begin
            hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + HOLD_CNT_W'(1);
        end
    end

    assign cpu_gnt_o = cpu_gnt_q;
    assign dma_gnt_o = dma_gnt_q;
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Self-checking bench for wb_dma_arbiter: directed scenarios plus a random soak against a reference model.
module tb_wb_dma_arbiter;

    localparam int NDMA     = 2;
    localparam int MAX_HOLD = 8;
    localparam int CPU_MIN  = 4;
    localparam int SOAK     = 20000;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_cyc;
    logic            cpu_gnt;
    logic [NDMA-1:0] req;
    logic [NDMA-1:0] dcyc;
    logic [NDMA-1:0] gnt;
    logic            pre;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_dma_arbiter #(.NDMA(NDMA), .MAX_HOLD(MAX_HOLD), .CPU_MIN(CPU_MIN)) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cpu_cyc_i (cpu_cyc),
        .cpu_gnt_o (cpu_gnt),
        .dma_req_i (req),
        .dma_cyc_i (dcyc),
        .dma_gnt_o (gnt),
        .preempt_o (pre)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, tracked as owner/phase bookkeeping.
    bit m_cpu, m_gap, m_pre;
    int m_owner, m_drain, m_cand, m_cpu_clk, m_tenure, m_rr;

    task automatic model_reset();
        m_cpu = 1; m_gap = 0; m_pre = 0;
        m_owner = -1; m_drain = -1; m_cand = -1;
        m_cpu_clk = 1000; m_tenure = 0; m_rr = 0;
    endtask

    function automatic int choose(input logic [NDMA-1:0] r);
        for (int k = 0; k < NDMA; k++) begin
            int idx;
            idx = (m_rr + k) % NDMA;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NDMA-1:0] exp_gnt();
        return (m_owner >= 0) ? NDMA'(1 << m_owner) : '0;
    endfunction

    task automatic model_step(input logic [NDMA-1:0] r, input logic cc, input logic [NDMA-1:0] dc);
        m_pre = 0;
        if (m_cpu) begin
            if (r != 0 && !cc && m_cpu_clk >= CPU_MIN) begin
                m_cpu = 0; m_gap = 1; m_cand = choose(r);
            end else begin
                m_cpu_clk++;
            end
        end else if (m_gap) begin
            m_gap = 0;
            if (r[m_cand]) begin
                m_owner = m_cand; m_tenure = 1;
`ifdef WB_ARB_RR_EN
                m_rr = (m_cand + 1) % NDMA;
`endif
            end else begin
                m_cpu = 1; m_cpu_clk = 1;
            end
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_drain = m_owner; m_owner = -1;
            end else if (MAX_HOLD != 0 && m_tenure >= MAX_HOLD) begin
                m_drain = m_owner; m_owner = -1; m_pre = 1;
            end else begin
                m_tenure++;
            end
        end else if (!dc[m_drain]) begin
            m_drain = -1; m_cpu = 1; m_cpu_clk = 1;
        end
    endtask

    // One clock: model follows the inputs seen at the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(req, cpu_cyc, dcyc);
        @(negedge clk);
        check("model_cpu_gnt", cpu_gnt, m_cpu);
        check("model_dma_gnt", gnt, exp_gnt());
        check("model_preempt", pre, m_pre);
        check("onehot0", $onehot0({cpu_gnt, gnt}), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_cpu, n_hold, n_pre, max_wait;
        int waits[NDMA];

        rst = 1'b1; req = '0; dcyc = '0; cpu_cyc = 1'b0;
        model_reset();
        #1;
        check("rst_cpu_gnt", cpu_gnt, 1);
        check("rst_dma_gnt", gnt, 0);
        check("rst_preempt", pre, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a DMA tenure drops the grant immediately.
        req = 2'b01;
        tick(); tick();
        check("t1_gnt", gnt, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("t1_rst_dma_gnt", gnt, 0);
        check("t1_rst_cpu_gnt", cpu_gnt, 1);
        check("t1_rst_preempt", pre, 0);
        model_reset();
        req = '0;
        #1 rst = 1'b0;

        // CPU busy holds off the handover until its cycle ends.
        cpu_cyc = 1'b1; req = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t2_cpu_hold", cpu_gnt, 1);
        end
        cpu_cyc = 1'b0;
        tick();
        check("t2_drop_cpu", cpu_gnt, 0);
        check("t2_drop_dma", gnt, 0);
        tick();
        check("t2_gnt", gnt, 2'b01);
        req = '0;
        tick();
        check("t2_rel", cpu_gnt, 0);
        tick();
        check("t2_ret", cpu_gnt, 1);

        // Two requesters: index 0 first, then CPU keeps the bus CPU_MIN clocks, then index 1.
        repeat (CPU_MIN) tick();
        req = 2'b11;
        tick(); tick();
        check("t3_first", gnt, 2'b01);
        req = 2'b10;
        tick(); tick();
        check("t3_ret", cpu_gnt, 1);
        n_cpu = 1;
        for (int k = 0; k < 30 && cpu_gnt; k++) begin
            tick();
            if (cpu_gnt) n_cpu++;
        end
        check("t3_cpu_min", n_cpu, CPU_MIN);
        tick();
        check("t3_second", gnt, 2'b10);
        req = '0;
        tick(); tick();
        repeat (CPU_MIN) tick();
        req = 2'b11;
        tick(); tick();
        check("t3_third", gnt, 2'b01);
        req = '0;
        repeat (3) tick();

        // Preemption after MAX_HOLD clocks; in-flight cycle delays the CPU's return.
        repeat (CPU_MIN) tick();
        req = 2'b01; dcyc = 2'b01;
        tick(); tick();
        check("t4_gnt", gnt, 2'b01);
        n_hold = 1; n_pre = 0;
        for (int k = 0; k < 40 && gnt[0]; k++) begin
            tick();
            if (gnt[0]) n_hold++;
            n_pre += int'(pre);
        end
        check("t4_hold", n_hold, MAX_HOLD);
        check("t4_pre_now", pre, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_wait_cyc", cpu_gnt, 0);
            n_pre += int'(pre);
        end
        dcyc = '0; req = '0;
        tick();
        check("t4_ret", cpu_gnt, 1);
        n_pre += int'(pre);
        check("t4_pulses", n_pre, 1);

        // Request withdrawn after one clock: dead cycle, then straight back to the CPU.
        repeat (CPU_MIN) tick();
        req = 2'b01;
        tick();
        check("t5_drop", cpu_gnt, 0);
        req = '0;
        tick();
        check("t5_back", cpu_gnt, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_no_gnt", gnt, 0);
        end

        // Random soak against the model.
        max_wait = 0;
        for (int i = 0; i < NDMA; i++) waits[i] = 0;
        for (int c = 0; c < SOAK; c++) begin
            for (int i = 0; i < NDMA; i++) begin
                if (!req[i])     req[i] = ($urandom_range(0, 7) == 0);
                else if (gnt[i]) req[i] = ($urandom_range(0, 5) != 0);
                else             req[i] = ($urandom_range(0, 39) != 0);
                if (gnt[i])       dcyc[i] = ($urandom_range(0, 1) == 1);
                else if (dcyc[i]) dcyc[i] = ($urandom_range(0, 1) == 1);
            end
            cpu_cyc = ($urandom_range(0, 2) == 0);
            tick();
            for (int i = 0; i < NDMA; i++) begin
                if (!req[i] || m_owner == i) waits[i] = 0;
                else if (m_owner >= 0 && m_tenure == 1) waits[i]++;
                if (waits[i] > max_wait) max_wait = waits[i];
            end
        end
`ifdef WB_ARB_RR_EN
        check("soak_no_starve", (max_wait < NDMA), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
